combo_lock_fsm: RTL
===================

Name: combo_lock_fsm

Overview:
Parametrised combination-lock controller, the successor to the fixed 6-digit, 4-bit-switch lock. It accepts digits through a valid strobe rather than one per clock, and supports a programmable code, a failed-attempt counter and a timed lockout. A separate display block decodes its registered status outputs to the HEX displays.

Parameters:
CODE_LEN, 6, number of digits in the code (>=2)
DIGIT_W, 4, bits per digit
MAX_DIGIT, 9, largest legal digit value; larger values are rejected
DEFAULT_CODE, 24'h665239, code loaded at reset (CODE_LEN*DIGIT_W bits); first-entered digit is the MS digit
MAX_FAILS, 3, consecutive wrong sequences that trigger lockout (>=1)
LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
digit_in  in  DIGIT_W  digit value, sampled only when digit_valid=1
digit_valid  in  1  one-cycle strobe; one digit per asserted cycle
relock  in  1  from OPEN/CLOSED/PROG, return to ENTER
prog_req  in  1  in OPEN, start entry of a new code
unlocked  out  1  high in OPEN and PROG
closed  out  1  high in CLOSED
lockout  out  1  high in LOCKOUT
bad_digit  out  1  one-cycle pulse on a rejected digit
pos  out  $clog2(CODE_LEN+1)  number of digits accepted in the current sequence
fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failed sequences
state  out  3  ENTER=0, OPEN=1, CLOSED=2, PROG=3, LOCKOUT=4

Behaviour:
- Reset (highest priority, synchronous, active-high):
  - state=ENTER, code=DEFAULT_CODE, pos=0, internal mismatch flag err=0, fail_cnt=0, timer=0.
  - All outputs 0.
- All outputs are registered. A transition taken at edge N is visible after edge N.
- Legal digit: digit_valid=1 and digit_in<=MAX_DIGIT.
  - digit_valid=1 with digit_in>MAX_DIGIT: bad_digit=1 for the next cycle only; pos/err/state unchanged.
  - This applies in ENTER and PROG. In all other states digit_valid is ignored and bad_digit stays 0.
- ENTER:
  - Each legal digit is compared with code digit[pos], where digit 0 = bits [CODE_LEN*DIGIT_W-1 -: DIGIT_W].
  - err |= mismatch; pos++.
  - A mismatch does not abort: all CODE_LEN digits are always collected.
  - On the legal digit that makes pos reach CODE_LEN, evaluate at that edge:
    - err==0 and last digit matches: -> OPEN, fail_cnt=0.
    - otherwise, fail_cnt+1==MAX_FAILS: -> LOCKOUT, timer=LOCKOUT_CYCLES-1, fail_cnt=MAX_FAILS.
    - otherwise: -> CLOSED, fail_cnt++.
    - In every case pos=0, err=0.
  - relock in ENTER: pos=0, err=0 (restart the sequence).
- OPEN:
  - relock -> ENTER. relock has priority over prog_req when both are asserted in the same cycle.
  - prog_req -> PROG, pos=0.
- PROG:
  - Each legal digit is written to a shadow register at position pos; pos++.
  - After the CODE_LEN-th digit: code<=shadow in one atomic update, -> OPEN, pos=0.
  - relock before completion: abort, code unchanged, -> ENTER, pos=0.
- CLOSED: holds until relock -> ENTER. fail_cnt is retained.
- LOCKOUT:
  - relock and prog_req are ignored.
  - timer decrements every cycle. In the cycle timer==0: -> ENTER, fail_cnt=0.
  - lockout is high for exactly LOCKOUT_CYCLES cycles.
- fail_cnt saturates at MAX_FAILS. It clears on a successful open or on lockout expiry.
- Unused state encodings recover to ENTER on the next edge with pos=0, err=0.
- Reset mid-PROG discards the shadow and restores DEFAULT_CODE.

Test Plan:
- Reset, then strobe 6,6,5,2,3,9 with idle gaps between strobes -> unlocked=1 after the 6th strobe edge; state=1, pos=0, fail_cnt=0.
- From reset, strobe 6,6,5,2,3,8 -> closed=1, fail_cnt=1, pos=0; then relock -> state=0, closed=0, fail_cnt=1.
- With MAX_FAILS=3 and LOCKOUT_CYCLES=8, enter three wrong sequences (relock between them):
  - lockout=1 for exactly 8 cycles;
  - digits and relock strobed during lockout have no effect;
  - afterwards state=0, fail_cnt=0;
  - the correct code then opens.
- Open, then prog_req, then strobe 1,2,3,4,5,6 -> unlocked stays 1 throughout, state returns to 1.
  - relock; entering 6,6,5,2,3,9 -> closed=1.
  - relock; entering 1,2,3,4,5,6 -> unlocked=1.
- Strobe 6,6,0xA,5,2,3,9 -> bad_digit pulses for one cycle after 0xA, pos stays 2, final unlocked=1.
- In OPEN, assert relock+prog_req in the same cycle -> state=0.
  - Then open, prog_req, enter 3 digits, assert rst -> state=0, code=DEFAULT_CODE (6,6,5,2,3,9 opens).

Source files
------------

// File: rtl/combo_lock_fsm.sv
// Combination-lock controller with a programmable code, a failed-attempt
// counter and a timed lockout. Digits arrive on a valid strobe, and all
// status outputs come straight from registers.
module combo_lock_fsm #(
   parameter int CODE_LEN       = 6,
   parameter int DIGIT_W        = 4,
   parameter int MAX_DIGIT      = 9,
   parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h665239,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [DIGIT_W-1:0]                 digit_in,
   input  logic                               digit_valid,
   input  logic                               relock,
   input  logic                               prog_req,
   output logic                               unlocked,
   output logic                               closed,
   output logic                               lockout,
   output logic                               bad_digit,
   output logic [$clog2(CODE_LEN+1)-1:0]      pos,
   output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
   output logic [2:0]                         state
);

   localparam int CODE_W = CODE_LEN * DIGIT_W;
   localparam int PW     = $clog2(CODE_LEN + 1);
   localparam int FW     = $clog2(MAX_FAILS + 1);
   localparam int TW     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_ENTER   = 3'd0,
      ST_OPEN    = 3'd1,
      ST_CLOSED  = 3'd2,
      ST_PROG    = 3'd3,
      ST_LOCKOUT = 3'd4
   } stateT;

   stateT             state_q, state_d;
   logic [PW-1:0]     pos_q, pos_d;
   logic              err_q, err_d;
   logic [FW-1:0]     fail_q, fail_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [CODE_W-1:0] shadow_q, shadow_d;
   logic              bad_q, bad_d;
   logic              unlocked_q, closed_q, lockout_q;

   logic [DIGIT_W-1:0] codeDigit;
   logic [CODE_W-1:0]  shadowWritten;
   logic               digitIllegal;
   logic               digitLegal;
   logic               digitMismatch;
   logic               lastDigit;
   logic               failHitsMax;

   assign digitIllegal  = digit_valid && (int'(digit_in) > MAX_DIGIT);
   assign digitLegal    = digit_valid && !digitIllegal;
   assign digitMismatch = (digit_in != codeDigit);
   assign lastDigit     = (pos_q == PW'(CODE_LEN - 1));
   assign failHitsMax   = ((int'(fail_q) + 1) == MAX_FAILS);

   // Pick the stored code digit at the current position and build the shadow
   // code with the incoming digit dropped into that same slot; digit 0 is the
   // most significant one.
   always_comb begin
      codeDigit     = '0;
      shadowWritten = shadow_q;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (pos_q == PW'(i)) begin
            codeDigit = code_q[CODE_W-1-i*DIGIT_W -: DIGIT_W];
            shadowWritten[CODE_W-1-i*DIGIT_W -: DIGIT_W] = digit_in;
         end
      end
   end

   // Next-state logic: sequence entry, code programming, failure accounting
   // and the lockout countdown.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      err_d    = err_q;
      fail_d   = fail_q;
      timer_d  = timer_q;
      code_d   = code_q;
      shadow_d = shadow_q;
      bad_d    = 1'b0;
      case (state_q)
         ST_ENTER: begin
            bad_d = digitIllegal;
            if (relock) begin
               pos_d = '0;
               err_d = 1'b0;
            end else if (digitLegal) begin
               if (lastDigit) begin
                  pos_d = '0;
                  err_d = 1'b0;
                  if (!err_q && !digitMismatch) begin
                     state_d = ST_OPEN;
                     fail_d  = '0;
                  end else if (failHitsMax) begin
                     state_d = ST_LOCKOUT;
                     timer_d = TW'(LOCKOUT_CYCLES - 1);
                     fail_d  = FW'(MAX_FAILS);
                  end else begin
                     state_d = ST_CLOSED;
                     if (fail_q < FW'(MAX_FAILS)) begin
                        fail_d = fail_q + FW'(1);
                     end
                  end
               end else begin
                  pos_d = pos_q + PW'(1);
                  err_d = err_q | digitMismatch;
               end
            end
         end
         ST_OPEN: begin
            if (relock) begin
               state_d = ST_ENTER;
               pos_d   = '0;
            end else if (prog_req) begin
               state_d = ST_PROG;
               pos_d   = '0;
            end
         end
         ST_PROG: begin
            bad_d = digitIllegal;
            if (relock) begin
               state_d = ST_ENTER;
               pos_d   = '0;
            end else if (digitLegal) begin
               shadow_d = shadowWritten;
               if (lastDigit) begin
                  code_d  = shadowWritten;
                  state_d = ST_OPEN;
                  pos_d   = '0;
               end else begin
                  pos_d = pos_q + PW'(1);
               end
            end
         end
         ST_CLOSED: begin
            if (relock) begin
               state_d = ST_ENTER;
            end
         end
         ST_LOCKOUT: begin
            if (timer_q == '0) begin
               state_d = ST_ENTER;
               fail_d  = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = ST_ENTER;
            pos_d   = '0;
            err_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers; status flags are registered from the
   // next state so they line up with the state output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_ENTER;
         pos_q      <= '0;
         err_q      <= 1'b0;
         fail_q     <= '0;
         timer_q    <= '0;
         code_q     <= DEFAULT_CODE;
         shadow_q   <= '0;
         bad_q      <= 1'b0;
         unlocked_q <= 1'b0;
         closed_q   <= 1'b0;
         lockout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         err_q      <= err_d;
         fail_q     <= fail_d;
         timer_q    <= timer_d;
         code_q     <= code_d;
         shadow_q   <= shadow_d;
         bad_q      <= bad_d;
         unlocked_q <= (state_d == ST_OPEN) || (state_d == ST_PROG);
         closed_q   <= (state_d == ST_CLOSED);
         lockout_q  <= (state_d == ST_LOCKOUT);
      end
   end

   assign unlocked  = unlocked_q;
   assign closed    = closed_q;
   assign lockout   = lockout_q;
   assign bad_digit = bad_q;
   assign pos       = pos_q;
   assign fail_cnt  = fail_q;
   assign state     = state_q;

endmodule
